// File: rtl/prog_mem_if.sv
// CPU fetch bus and loader write port for prog_mem.
// The master side is the CPU/loader; the slave side is the memory.
interface prog_mem_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8
) ();
  logic [ADDR_W-1:0]     addr;
  logic                  refetch;
  logic                  ld_we;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [DATA_W-1:0]     ld_data;
  logic [DATA_W-1:0]     data;
  logic                  RAM_ready;
  logic                  busy;

  modport master (
    output addr, refetch, ld_we, ld_addr, ld_data,
    input  data, RAM_ready, busy
  );

  modport slave (
    input  addr, refetch, ld_we, ld_addr, ld_data,
    output data, RAM_ready, busy
  );
endinterface

// File: rtl/prog_mem.sv
// Word-addressed program memory with a latency-programmable ready pulse.
// state | meaning
// IDLE  | waiting for a new address, a refetch, or the first fetch after reset
// BUSY  | read in flight; counter runs down to the completion edge
module prog_mem #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input logic      clk,
  input logic      rst,
  prog_mem_if.slave bus
);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;

  // Contents survive reset; the loader may write in any state.
  always_ff @(posedge clk) begin
    if (bus.ld_we) mem[bus.ld_addr] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      first_q <= 1'b1;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      first_q <= first_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    first_d = first_q;
    data_d  = data_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (first_q || (bus.addr != last_q) || bus.refetch) begin
          last_d  = bus.addr;
          first_d = 1'b0;
          cnt_d   = LAT_M1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // An address change outranks completion: the stale word is never reported.
        if (bus.addr != last_q) begin
          last_d = bus.addr;
          cnt_d  = LAT_M1;
        end else if (cnt_q == '0) begin
          data_d  = mem[last_q[DEPTH_LOG2-1:0]];
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data      = data_q;
  assign bus.RAM_ready = ready_q;
  assign bus.busy      = (state_q == BUSY);
endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
- Word-addressed program/data memory with a ready handshake, sitting directly upstream of the CPU.
- Consumes the CPU's 16-bit fetch address and returns a 16-bit word plus a one-cycle ready pulse after a programmable latency. These feed the CPU's data and RAM_ready inputs.
- Also takes the CPU's CU_rst strobe as a refetch request.
- A separate loader write port preloads or patches contents.

Parameters:
- DATA_W, 16, word width.
- ADDR_W, 16, width of CPU address input.
- DEPTH_LOG2, 8, log2 of word count; array holds 2^DEPTH_LOG2 words.
- LATENCY, 2, cycles from request acceptance to ready pulse; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  ADDR_W  fetch address from the CPU.
- refetch  input  1  re-read the current address even if unchanged; driven by the CPU's CU_rst.
- ld_we  input  1  loader write enable.
- ld_addr  input  DEPTH_LOG2  loader write address.
- ld_data  input  DATA_W  loader write data.
- data  output  DATA_W  read word, registered.
- RAM_ready  output  1  one-cycle pulse: data is valid for the current request.
- busy  output  1  read in flight.

Behaviour:
- Reset (rst=0, asynchronous):
  - data=0, RAM_ready=0, busy=0, state=IDLE, latency counter=0.
  - first-fetch flag set; last_addr=0.
  - Array contents are NOT cleared.
  - Reset asserted mid-read aborts the read; no ready pulse follows.
- Indexing: array index = addr[DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses wrap modulo 2^DEPTH_LOG2.
- Trigger: in IDLE, a request is accepted in cycle T when any of the following holds:
  - first-fetch flag set;
  - addr != last_addr;
  - refetch=1.
- On acceptance:
  - last_addr<=addr; first-fetch flag cleared.
  - counter<=LATENCY-1; state<=BUSY; busy=1 from T+1.
- BUSY:
  - Counter decrements each cycle.
  - On the edge where counter==0 is seen: data<=mem[index], RAM_ready<=1, busy<=0, state<=IDLE.
  - Net result: data and RAM_ready are visible in cycle T+LATENCY.
  - LATENCY=1 gives ready in the cycle after acceptance.
- RAM_ready is high for exactly one cycle per completed request and is never high while busy=1.
- data holds its value between completions; it changes only on a completion edge or on reset.
- Address change while BUSY:
  - Abort and restart: last_addr<=new addr; counter reloads to LATENCY-1.
  - No ready pulse for the abandoned address.
  - Ready arrives LATENCY cycles after the change.
- refetch while BUSY: ignored; the in-flight read already serves the current address.
- Completion and new trigger in the same cycle:
  - The trigger is evaluated in the cycle after RAM_ready (state is IDLE then).
  - Minimum spacing between ready pulses is therefore LATENCY+1 cycles.
- Loader:
  - ld_we=1 writes mem[ld_addr]<=ld_data on the rising edge, in any state.
  - Writes do not disturb the FSM and do not trigger a read.
- Write/read collision (ld_we to the same index on the completion edge): read-before-write. data returns the old word; the new word is visible to later reads.
- Reading a never-written location returns X in simulation; benches must preload.
- FSM states: IDLE and BUSY only. No illegal-state recovery is needed beyond reset.

Test Plan:
- Reset then addr=16'h0032, mem[0x32]=16'hA5A5 preloaded, LATENCY=2:
  - RAM_ready pulses one cycle, exactly 2 cycles after the first post-reset edge, with data=16'hA5A5;
  - busy is high only in between.
- Steady addr=0x32 for 20 cycles after the first ready -> no further RAM_ready pulses. Then refetch=1 for one cycle -> one new pulse 2 cycles later, data unchanged.
- Sequential fetch 0x32,0x33,0x34, each presented the cycle after the previous ready, with words 0x1111/0x2222/0x3333 -> three pulses spaced 3 cycles apart with those values in order.
- Abort case:
  - stimulus: addr changes 0x32->0x40 one cycle after acceptance;
  - required: no pulse for 0x32; single pulse 2 cycles after the change with data=mem[0x40];
  - required: data keeps its previous value until that pulse.
- Collision case:
  - stimulus: ld_we writes 0xBEEF to index 0x32 on the completion edge of a read of 0x32 (old 0xA5A5);
  - required: data=0xA5A5; a subsequent refetch returns 0xBEEF.
- Reset mid-read: rst=0 while busy=1 -> data=0, RAM_ready=0, busy=0 immediately (asynchronous). After release, a fresh fetch of the same addr occurs with the standard latency.
- Wrap: DEPTH_LOG2=8, addr=0x0132 -> returns mem[0x32].
